imm_decode: RTL

IMM_DECODE -- requirements
Module: imm_decode

---
 rtl/rv64_pkg.sv | 58 +++++
 rtl/imm_gen.sv | 24 ++
 rtl/imm_decode.sv | 116 +++++++++++
 3 files changed

// File: rtl/rv64_pkg.sv
// Shared RV64 decode definitions: opcode constants, format enum and the buffered entry layout.
package rv64_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpImm32   = 7'b0011011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpOp32    = 7'b0111011;

  typedef enum logic [2:0] {
    FmtR    = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtNone = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [19:0]     imm20;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  localparam entry_t EntryRst = '{
    pc: '0, opcode: '0, rd: '0, imm20: '0, imm: '0, fmt: FmtNone, illegal: 1'b0
  };

  function automatic fmt_e opcode_fmt(logic [6:0] op);
    fmt_e f;
    case (op)
      OpLui, OpAuipc:                                      f = FmtU;
      OpJal:                                               f = FmtJ;
      OpJalr, OpLoad, OpImm, OpImm32, OpMiscMem, OpSystem: f = FmtI;
      OpStore:                                             f = FmtS;
      OpBranch:                                            f = FmtB;
      OpOp, OpOp32:                                        f = FmtR;
      default:                                             f = FmtNone;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV64 immediate construction from instruction word and decoded format.
module imm_gen
  import rv64_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  fmt_e            fmt_i,
  output logic [XLEN-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      FmtU: imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
      FmtI: imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
      FmtS: imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FmtB: imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
      FmtJ: imm_o = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_decode.sv
// RV64 instruction field/immediate decoder with a 2-entry (main + skid) output buffer.
module imm_decode
  import rv64_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [6:0]      out_opcode_o,
  output logic [4:0]      out_rd_o,
  output logic [19:0]     out_imm20_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [2:0]      out_fmt_o,
  output logic            out_illegal_o
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  entry_t          head_q, head_d, skid_q, skid_d;
  entry_t          dec;
  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            acc, drn;

  // Quadrant bits other than 2'b11 are compressed/reserved encodings: never legal here.
  assign dec_fmt = (in_instr_i[1:0] == 2'b11) ? opcode_fmt(in_instr_i[6:0]) : FmtNone;

  imm_gen u_imm_gen (
    .instr_i (in_instr_i),
    .fmt_i   (dec_fmt),
    .imm_o   (dec_imm)
  );

  always_comb begin
    dec         = EntryRst;
    dec.pc      = in_pc_i;
    dec.opcode  = in_instr_i[6:0];
    dec.rd      = in_instr_i[11:7];
    dec.imm20   = (dec_fmt == FmtU) ? in_instr_i[31:12] : 20'b0;
    dec.imm     = dec_imm;
    dec.fmt     = dec_fmt;
    dec.illegal = (dec_fmt == FmtNone);
  end

  assign acc = in_valid_i & in_ready_q;
  assign drn = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (acc) begin
          state_d = StOne;
          head_d  = dec;
        end
        StOne: begin
          case ({acc, drn})
            2'b11: head_d = dec;
            2'b10: begin
              state_d = StTwo;
              skid_d  = dec;
            end
            2'b01: state_d = StEmpty;
            default: ;
          endcase
        end
        StTwo: if (drn) begin
          state_d = StOne;
          head_d  = skid_q;
        end
        default: state_d = StEmpty;
      endcase
    end
    // Registered so out_ready never reaches in_ready combinationally.
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      head_q     <= EntryRst;
      skid_q     <= EntryRst;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = (state_q != StEmpty);
  assign out_pc_o      = head_q.pc;
  assign out_opcode_o  = head_q.opcode;
  assign out_rd_o      = head_q.rd;
  assign out_imm20_o   = head_q.imm20;
  assign out_imm_o     = head_q.imm;
  assign out_fmt_o     = head_q.fmt;
  assign out_illegal_o = head_q.illegal;

endmodule
